// File: rtl/regbank_write_sched.sv
// -----------------------------------------------------------------------------
// regbank_write_sched
// Write-back scheduler for the 8x8 register bank. Four write sources are
// arbitrated round-robin; the winner index drives the bank source select
// (ms1/ms0), its destination drives the register select (rs2..rs0), and the
// bank write strobe e is sequenced as setup / pulse / hold so that the
// falling edge of e captures stable data. One register write per transaction.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active high
//   en_i         start enable; low only blocks new arbitration
//   req_i[3:0]   write requests: [0]=ALU [1]=REG [2]=IMM [3]=MEM
//   dst_i[11:0]  destination register per requester, dst_i[3i+2:3i]
//   gnt_o[3:0]   one-hot, one-cycle completion pulse to the winner
//   busy_o       high in every state except IDLE
//   ms1_o/ms0_o  bank source select = winner index
//   rs2_o..rs0_o bank destination select = latched dst of winner
//   e_o          bank write enable/clock, capture on falling edge
//
// state  | meaning
// IDLE   | waiting for en_i && |req_i; arbitrates from ptr
// SETUP  | ms/rs stable, e low, SETUP_CYC cycles
// STROBE | e high, PULSE_CYC cycles
// HOLD   | e low after the capture edge, HOLD_CYC cycles
// DONE   | gnt pulse to winner, ptr advances; no arbitration here
// -----------------------------------------------------------------------------
module regbank_write_sched #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned PULSE_CYC = 1,
    parameter int unsigned HOLD_CYC  = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [3:0]  req_i,
    input  logic [11:0] dst_i,
    output logic [3:0]  gnt_o,
    output logic        busy_o,
    output logic        ms1_o,
    output logic        ms0_o,
    output logic        rs2_o,
    output logic        rs1_o,
    output logic        rs0_o,
    output logic        e_o
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);
    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYC - 1);
    localparam logic [3:0] HOLD_LAST  = 4'(HOLD_CYC - 1);

    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] ptr_q;
    logic [3:0] gnt_q;
    logic       busy_q;
    logic       e_q;
    logic [1:0] ms_q;
    logic [2:0] rs_q;

    logic [1:0] win_d;
    logic [2:0] rs_d;
    logic       found_d;
    logic [1:0] idx;

    // Round-robin scan starting at ptr_q; first set request wins.
    always_comb begin
        win_d   = ptr_q;
        found_d = 1'b0;
        idx     = ptr_q;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found_d && req_i[idx]) begin
                win_d   = idx;
                found_d = 1'b1;
            end
        end
        rs_d = 3'(dst_i >> (32'd3 * 32'(win_d)));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            e_q     <= 1'b0;
            ms_q    <= '0;
            rs_q    <= '0;
        end else begin
            gnt_q <= '0;
            case (state_q)
                IDLE: begin
                    e_q <= 1'b0;
                    if (en_i && found_d) begin
                        state_q <= SETUP;
                        cnt_q   <= '0;
                        ms_q    <= win_d;
                        rs_q    <= rs_d;
                        busy_q  <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        state_q <= STROBE;
                        cnt_q   <= '0;
                        e_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                STROBE: begin
                    if (cnt_q == PULSE_LAST) begin
                        // falling edge of e here is the bank capture edge
                        state_q <= HOLD;
                        cnt_q   <= '0;
                        e_q     <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        gnt_q   <= 4'b0001 << ms_q;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    ptr_q   <= ms_q + 2'd1;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    e_q     <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;
    assign ms1_o  = ms_q[1];
    assign ms0_o  = ms_q[0];
    assign rs2_o  = rs_q[2];
    assign rs1_o  = rs_q[1];
    assign rs0_o  = rs_q[0];
    assign e_o    = e_q;

endmodule

// File: tb/tb_regbank_write_sched.sv
// Bench for regbank_write_sched: two instances (default timing and 2/3/1
// timing) share one stimulus stream; a transaction-level reference model
// predicts every output of both instances each cycle.
module tb_regbank_write_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en;
    logic [3:0]  req;
    logic [11:0] dst;

    logic [3:0] gnt_a, gnt_b;
    logic busy_a, ms1_a, ms0_a, rs2_a, rs1_a, rs0_a, e_a;
    logic busy_b, ms1_b, ms0_b, rs2_b, rs1_b, rs0_b, e_b;

    regbank_write_sched dut_a (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .dst_i(dst),
        .gnt_o(gnt_a), .busy_o(busy_a), .ms1_o(ms1_a), .ms0_o(ms0_a),
        .rs2_o(rs2_a), .rs1_o(rs1_a), .rs0_o(rs0_a), .e_o(e_a)
    );

    regbank_write_sched #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .en_i(en), .req_i(req), .dst_i(dst),
        .gnt_o(gnt_b), .busy_o(busy_b), .ms1_o(ms1_b), .ms0_o(ms0_b),
        .rs2_o(rs2_b), .rs1_o(rs1_b), .rs0_o(rs0_b), .e_o(e_b)
    );

    // {gnt[3:0], busy, ms[1:0], rs[2:0], e}
    logic [10:0] obs [2];
    assign obs[0] = {gnt_a, busy_a, ms1_a, ms0_a, rs2_a, rs1_a, rs0_a, e_a};
    assign obs[1] = {gnt_b, busy_b, ms1_b, ms0_b, rs2_b, rs1_b, rs0_b, e_b};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a transaction started at edge t0 occupies phases
    // j = 1..S (setup), S+1..S+P (strobe), S+P+1..S+P+H (hold), S+P+H+1 (done).
    int SC [2] = '{1, 2};
    int PC [2] = '{1, 3};
    int HC [2] = '{1, 1};
    bit m_act [2];
    int m_t0  [2];
    int m_win [2];
    int m_ptr [2];
    int m_ms  [2];
    int m_rs  [2];

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            int len;
            len = SC[i] + PC[i] + HC[i];
            if (rst) begin
                m_act[i] = 0; m_ptr[i] = 0; m_ms[i] = 0; m_rs[i] = 0;
            end else if (m_act[i]) begin
                if (cyc == m_t0[i] + len + 1) begin
                    m_act[i] = 0;
                    m_ptr[i] = (m_win[i] + 1) % 4;
                end
            end else if (en && req != 4'd0) begin
                for (int k = 0; k < 4; k++) begin
                    if (req[(m_ptr[i] + k) % 4]) begin
                        m_win[i] = (m_ptr[i] + k) % 4;
                        break;
                    end
                end
                m_act[i] = 1;
                m_t0[i]  = cyc;
                m_ms[i]  = m_win[i];
                m_rs[i]  = (dst >> (3 * m_win[i])) & 7;
            end
        end
    endtask

    function automatic logic [10:0] expv(int i);
        int j, len;
        logic [3:0] g;
        logic ev;
        j   = cyc - m_t0[i] + 1;
        len = SC[i] + PC[i] + HC[i];
        g   = 4'd0;
        ev  = 1'b0;
        if (m_act[i]) begin
            ev = (j > SC[i]) && (j <= SC[i] + PC[i]);
            if (j == len + 1) g = 4'b0001 << m_win[i];
        end
        return {g, logic'(m_act[i]), 2'(m_ms[i]), 3'(m_rs[i]), ev};
    endfunction

    task automatic chk(string tag, logic [31:0] o, logic [31:0] x);
        checks++;
        assert (o === x) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, o, x);
        end
    endtask

    task automatic step(int n = 1);
        repeat (n) begin
            model_edge();
            @(posedge clk);
            @(negedge clk);
            chk("model_a", 32'(obs[0]), 32'(expv(0)));
            chk("model_b", 32'(obs[1]), 32'(expv(1)));
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    int gidx [$];
    int gcyc [$];

    initial begin
        rst = 1'b1; en = 1'b0; req = 4'd0; dst = 12'd0;
        step(2);
        chk("reset_outputs_a", 32'(obs[0]), 32'd0);

        // 1: single ALU write, default timing
        rst = 1'b0; en = 1'b1; req = 4'b0001; dst = 12'd3;
        step();
        chk("t1_ms_rs", 32'({ms1_a, ms0_a, rs2_a, rs1_a, rs0_a}), 32'b00011);
        chk("t1_e_setup", 32'(e_a), 32'd0);
        step();
        chk("t1_e_strobe", 32'(e_a), 32'd1);
        step();
        chk("t1_e_hold", 32'(e_a), 32'd0);
        step();
        chk("t1_gnt", 32'(gnt_a), 32'b0001);
        req = 4'd0;
        step();
        chk("t1_busy_done", 32'(busy_a), 32'd0);
        step(6);

        // 6: slow-timing instance, IMM request from reset
        do_reset();
        req = 4'b0100; dst = 12'd0;
        for (int j = 1; j <= 7; j++) begin
            step();
            chk("t6_e", 32'(e_b), (j >= 3 && j <= 5) ? 32'd1 : 32'd0);
            chk("t6_gnt", 32'(gnt_b), (j == 7) ? 32'b0100 : 32'd0);
        end
        req = 4'd0;
        step(8);

        // 2: all requesting -> rotation 0,1,2,3,0 on the default instance
        do_reset();
        req = 4'b1111; dst = 12'b101101101101;
        gidx.delete(); gcyc.delete();
        for (int t = 0; t < 60 && gidx.size() < 5; t++) begin
            step();
            if (gnt_a != 4'd0) begin
                gidx.push_back($clog2(int'(gnt_a)));
                gcyc.push_back(cyc);
                chk("t2_ms_at_gnt", 32'({ms1_a, ms0_a}), 32'(gidx[gidx.size()-1]));
                chk("t2_rs_at_gnt", 32'({rs2_a, rs1_a, rs0_a}), 32'd5);
            end
        end
        chk("t2_grant_count", 32'(gidx.size()), 32'd5);
        for (int g = 0; g < gidx.size(); g++) begin
            chk("t2_order", 32'(gidx[g]), 32'(g % 4));
            if (g > 0) chk("t2_spacing", 32'(gcyc[g] - gcyc[g-1]), 32'd5);
        end
        req = 4'd0;
        step(8);

        // 3: after an ALU grant, MEM is ahead of ALU
        do_reset();
        req = 4'b0001; dst = 12'o7000;
        for (int t = 0; t < 20 && gnt_a == 4'd0; t++) step();
        chk("t3_first_gnt", 32'(gnt_a), 32'b0001);
        req = 4'b1001;
        step(2);
        chk("t3_ms_mem", 32'({ms1_a, ms0_a}), 32'b11);
        for (int t = 0; t < 20 && gnt_a == 4'd0; t++) step();
        chk("t3_second_gnt", 32'(gnt_a), 32'b1000);
        req = 4'd0;
        step(8);

        // 4: reset during strobe
        do_reset();
        req = 4'b0100;
        for (int t = 0; t < 20 && e_a == 1'b0; t++) step();
        chk("t4_in_strobe", 32'(e_a), 32'd1);
        rst = 1'b1;
        step();
        chk("t4_after_rst", 32'({gnt_a, busy_a, e_a}), 32'd0);
        rst = 1'b0;
        for (int t = 0; t < 20 && gnt_a == 4'd0; t++) step();
        chk("t4_restart_gnt", 32'(gnt_a), 32'b0100);
        req = 4'd0;
        step(8);

        // 5: en low blocks arbitration
        do_reset();
        en = 1'b0; req = 4'b0010;
        for (int t = 0; t < 10; t++) begin
            step();
            chk("t5_idle", 32'({busy_a, e_a, busy_b, e_b}), 32'd0);
        end
        en = 1'b1;
        step();
        chk("t5_start", 32'({busy_a, busy_b}), 32'b11);
        en = 1'b0;
        step(12);

        // random traffic, including en drops, req drops and occasional reset
        en = 1'b1;
        for (int t = 0; t < 400; t++) begin
            rst = ($urandom_range(0, 59) == 0);
            en  = ($urandom_range(0, 3) != 0);
            req = 4'($urandom);
            dst = 12'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
